// File: rtl/divider.sv
// rtl/divider.sv - 32-bit sequential restoring divider, one quotient bit per cycle, 33-cycle latency.
// Optional two's complement operation when SIGNED_DIV_EN is defined.
module divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [63:0] r_work;
    logic [31:0] r_div;
    logic [31:0] r_a;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_diff;
    logic        w_borrow;
    logic [63:0] w_step;
    logic [31:0] w_q_res;
    logic [31:0] w_r_res;

`ifdef SIGNED_DIV_EN
    logic r_q_neg;
    logic r_r_neg;

    assign w_mag_a = a[31] ? (32'd0 - a) : a;
    assign w_mag_b = b[31] ? (32'd0 - b) : b;
    assign w_q_res = r_q_neg ? (32'd0 - r_work[31:0])  : r_work[31:0];
    assign w_r_res = r_r_neg ? (32'd0 - r_work[63:32]) : r_work[63:32];
`else
    assign w_mag_a = a;
    assign w_mag_b = b;
    assign w_q_res = r_work[31:0];
    assign w_r_res = r_work[63:32];
`endif

    // The shifted partial remainder is 33 bits wide, so compare it in full before dropping the top bit.
    assign w_diff   = r_work[63:31] - {1'b0, r_div};
    assign w_borrow = w_diff[32];
    assign w_step   = w_borrow ? {r_work[62:0], 1'b0}
                               : {w_diff[31:0], r_work[30:0], 1'b1};

    assign busy = (r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_RUN;
            S_RUN:    if (r_cnt == 5'd31) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= 32'd0;
            r      <= 32'd0;
            dbz    <= 1'b0;
            done   <= 1'b0;
            r_cnt  <= 5'd0;
            r_work <= 64'd0;
            r_div  <= 32'd0;
            r_a    <= 32'd0;
`ifdef SIGNED_DIV_EN
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work <= {32'd0, w_mag_a};
                        r_div  <= w_mag_b;
                        r_a    <= a;
                        r_cnt  <= 5'd0;
`ifdef SIGNED_DIV_EN
                        r_q_neg <= a[31] ^ b[31];
                        r_r_neg <= a[31];
`endif
                    end
                end
                S_RUN: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt + 5'd1;
                end
                S_FINISH: begin
                    // Divide-by-zero reports the raw dividend so the result is sign-mode independent.
                    if (r_div == 32'd0) begin
                        q   <= 32'hFFFF_FFFF;
                        r   <= r_a;
                        dbz <= 1'b1;
                    end else begin
                        q   <= w_q_res;
                        r   <= w_r_res;
                        dbz <= 1'b0;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for divider.
module tb_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        dbz;

    int errors = 0;
    int checks = 0;

    divider dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    // Entered and left at a negedge. lat = posedges after acceptance until done is seen (-1 if never).
    task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v,
                           input int poke_at, input logic [31:0] pa, input logic [31:0] pb,
                           input int rst_at,
                           output int lat, output int busy_n, output bit held);
        logic [31:0] pq;
        logic [31:0] pr;
        logic        pd;
        int n;
        pq = q; pr = r; pd = dbz;
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0; busy_n = 0; held = 1'b1; lat = -1;
        while (n < 45) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
            if (q !== pq || r !== pr || dbz !== pd) held = 1'b0;
            start = (n == poke_at);
            if (n == poke_at) begin
                a = pa; b = pb;
            end
            reset = (n == rst_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; a = 32'd5; b = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checks++; if (q !== 32'd0)   begin errors++; $display("FAIL reset_q: got %h want 0", q); end
        checks++; if (r !== 32'd0)   begin errors++; $display("FAIL reset_r: got %h want 0", r); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (dbz !== 1'b0)  begin errors++; $display("FAIL reset_dbz: got %b want 0", dbz); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy: got %b want 0", busy); end
    endtask

    task automatic test_case(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic [31:0] eq, input logic [31:0] er, input logic ed);
        int lat, bn;
        bit held;
        run_div(ta, tb_v, -1, 32'd0, 32'd0, -1, lat, bn, held);
        checks++; if (lat !== 33) begin errors++; $display("FAIL %s_latency: got %0d want 33", name, lat); end
        checks++; if (bn !== 32)  begin errors++; $display("FAIL %s_busy_cycles: got %0d want 32", name, bn); end
        checks++; if (!held)      begin errors++; $display("FAIL %s_hold: got changed want held", name); end
        checks++; if (q !== eq)   begin errors++; $display("FAIL %s_q: got %h want %h", name, q, eq); end
        checks++; if (r !== er)   begin errors++; $display("FAIL %s_r: got %h want %h", name, r, er); end
        checks++; if (dbz !== ed) begin errors++; $display("FAIL %s_dbz: got %b want %b", name, dbz, ed); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b want 0", name, done); end
        checks++; if (q !== eq)   begin errors++; $display("FAIL %s_q_hold: got %h want %h", name, q, eq); end
    endtask

    task automatic test_basic;
        test_case("c1_17_3",   32'd17,        32'd3,  32'd5,         32'd2, 1'b0);
        test_case("c2_128_48", 32'd128,       32'd48, 32'd2,         32'd32, 1'b0);
        test_case("c2_max_1",  32'hFFFF_FFFF, 32'd1,  32'hFFFF_FFFF, 32'd0, 1'b0);
    endtask

    task automatic test_dbz;
        test_case("c3_dbz", 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1);
        test_case("dbz_clear", 32'd10, 32'd10, 32'd1, 32'd0, 1'b0);
    endtask

    task automatic test_ignore_start;
        int lat, bn;
        bit held;
        run_div(32'd100, 32'd7, 10, 32'd9, 32'd3, -1, lat, bn, held);
        checks++; if (lat !== 33)     begin errors++; $display("FAIL c4_latency: got %0d want 33", lat); end
        checks++; if (q !== 32'd14)   begin errors++; $display("FAIL c4_q: got %h want %h", q, 32'd14); end
        checks++; if (r !== 32'd2)    begin errors++; $display("FAIL c4_r: got %h want %h", r, 32'd2); end
        @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL c4_no_restart: got %b want 0", busy); end
    endtask

    task automatic test_abort_reset;
        int lat, bn;
        bit held;
        run_div(32'd100, 32'd7, -1, 32'd0, 32'd0, 15, lat, bn, held);
        checks++; if (lat !== -1)     begin errors++; $display("FAIL c5_no_done: got %0d want -1", lat); end
        checks++; if (bn !== 16)      begin errors++; $display("FAIL c5_busy_cycles: got %0d want 16", bn); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL c5_busy: got %b want 0", busy); end
        checks++; if (q !== 32'd0)    begin errors++; $display("FAIL c5_q: got %h want 0", q); end
        checks++; if (r !== 32'd0)    begin errors++; $display("FAIL c5_r: got %h want 0", r); end
        test_case("c5_restart", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    endtask

    task automatic test_back_to_back;
        int lat, bn;
        bit held;
        run_div(32'd50, 32'd6, -1, 32'd0, 32'd0, -1, lat, bn, held);
        checks++; if (q !== 32'd8)    begin errors++; $display("FAIL b2b_first_q: got %h want %h", q, 32'd8); end
        // Still in the done cycle: this start must be accepted.
        run_div(32'd1000, 32'd33, -1, 32'd0, 32'd0, -1, lat, bn, held);
        checks++; if (lat !== 33)     begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        checks++; if (bn !== 32)      begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 32", bn); end
        checks++; if (!held)          begin errors++; $display("FAIL b2b_hold: got changed want held"); end
        checks++; if (q !== 32'd30)   begin errors++; $display("FAIL b2b_q: got %h want %h", q, 32'd30); end
        checks++; if (r !== 32'd10)   begin errors++; $display("FAIL b2b_r: got %h want %h", r, 32'd10); end
        @(negedge clk);
    endtask

    task automatic test_sign_mode;
`ifdef SIGNED_DIV_EN
        test_case("c6_neg7_2",  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        test_case("min_neg1",   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
        test_case("s_7_neg2",   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
        test_case("s_dbz_neg",  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`else
        test_case("c6_neg7_2",  32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         1'b0);
        test_case("min_neg1",   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        test_case("u_7_big",    32'd7,         32'hFFFF_FFFE, 32'd0,         32'd7,         1'b0);
        test_case("u_dbz_big",  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_dbz;
        test_ignore_start;
        test_abort_reset;
        test_back_to_back;
        test_sign_mode;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
